// File: rtl/simon_round_engine.sv
// Iterative Simon block-cipher round engine: one block in flight, UNROLL rounds per clock,
// round keys held in a software-loaded store.
module simon_round_engine #(
    parameter int unsigned WORD_W = 16,
    parameter int unsigned ROUNDS = 32,
    parameter int unsigned UNROLL = 1,
    localparam int unsigned ADDR_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
    input  logic                  i_clk_simon,
    input  logic                  i_rst_simon,
    input  logic                  i_key_wr_en,
    input  logic [ADDR_W-1:0]     i_key_wr_addr,
    input  logic [WORD_W-1:0]     i_key_wr_data,
    output logic                  o_key_wr_err,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [2*WORD_W-1:0]   i_in_block,
    input  logic                  i_in_decrypt,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [2*WORD_W-1:0]   o_out_block,
    output logic                  o_out_decrypt,
    output logic                  o_busy
);

    // Counter must be able to hold ROUNDS itself (the terminal value).
    localparam int unsigned CNT_W = $clog2(ROUNDS + 1);

    if (UNROLL == 0 || (ROUNDS % UNROLL) != 0) begin : g_bad_unroll
        $error("simon_round_engine: UNROLL must divide ROUNDS");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             r_state;
    state_e             w_state_next;
    logic [WORD_W-1:0]  r_keys [ROUNDS];
    logic [WORD_W-1:0]  r_x;
    logic [WORD_W-1:0]  r_y;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_dec;
    logic               r_in_ready;
    logic               r_key_wr_err;
    logic [WORD_W-1:0]  w_x_next;
    logic [WORD_W-1:0]  w_y_next;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_accept;
    logic               w_key_ok;
    logic               w_out_valid;
    logic               w_busy;

    function automatic logic [WORD_W-1:0] rotl(input logic [WORD_W-1:0] v,
                                               input int unsigned n);
        return (v << n) | (v >> (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] simon_f(input logic [WORD_W-1:0] v);
        return (rotl(v, 1) & rotl(v, 8)) ^ rotl(v, 2);
    endfunction

    assign w_accept  = i_in_valid && r_in_ready;
    assign w_cnt_inc = r_cnt + CNT_W'(UNROLL);
    // Key writes only land while idle; a write coinciding with an accept is still used.
    assign w_key_ok  = i_key_wr_en && (r_state == StIdle) && (32'(i_key_wr_addr) < ROUNDS);

    // Chain UNROLL rounds combinationally; decrypt walks the key store from the top down.
    always_comb begin
        logic [WORD_W-1:0] x_t;
        logic [WORD_W-1:0] y_t;
        logic [WORD_W-1:0] t_t;
        logic [ADDR_W-1:0] kidx;
        x_t  = r_x;
        y_t  = r_y;
        t_t  = '0;
        kidx = '0;
        for (int unsigned u = 0; u < UNROLL; u++) begin
            if (r_dec) begin
                kidx = ADDR_W'(CNT_W'(ROUNDS - 1) - r_cnt - CNT_W'(u));
                t_t  = y_t;
                y_t  = x_t ^ simon_f(y_t) ^ r_keys[kidx];
                x_t  = t_t;
            end else begin
                kidx = ADDR_W'(r_cnt + CNT_W'(u));
                t_t  = x_t;
                x_t  = y_t ^ simon_f(x_t) ^ r_keys[kidx];
                y_t  = t_t;
            end
        end
        w_x_next = x_t;
        w_y_next = y_t;
    end

    // Next-state and status decode.
    always_comb begin
        w_state_next = r_state;
        w_out_valid  = 1'b0;
        w_busy       = 1'b1;
        unique case (r_state)
            StIdle: begin
                w_busy = 1'b0;
                if (w_accept) w_state_next = StRun;
            end
            StRun: begin
                if (w_cnt_inc == CNT_W'(ROUNDS)) w_state_next = StDone;
            end
            StDone: begin
                w_out_valid = 1'b1;
                if (i_out_ready) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    // State register; in_ready is registered from the next state so it rises right after hand-off.
    always_ff @(posedge i_clk_simon or posedge i_rst_simon) begin
        if (i_rst_simon) begin
            r_state    <= StIdle;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_in_ready <= (w_state_next == StIdle);
        end
    end

    // Block datapath: latch on accept, advance UNROLL rounds per RUN cycle, hold in DONE.
    always_ff @(posedge i_clk_simon or posedge i_rst_simon) begin
        if (i_rst_simon) begin
            r_x   <= '0;
            r_y   <= '0;
            r_cnt <= '0;
            r_dec <= 1'b0;
        end else begin
            if (r_state == StIdle && w_accept) begin
                r_x   <= i_in_block[2*WORD_W-1:WORD_W];
                r_y   <= i_in_block[WORD_W-1:0];
                r_dec <= i_in_decrypt;
                r_cnt <= '0;
            end else if (r_state == StRun) begin
                r_x   <= w_x_next;
                r_y   <= w_y_next;
                r_cnt <= w_cnt_inc;
            end
        end
    end

    // Round-key store and dropped-write pulse.
    always_ff @(posedge i_clk_simon or posedge i_rst_simon) begin
        if (i_rst_simon) begin
            for (int unsigned i = 0; i < ROUNDS; i++) r_keys[i] <= '0;
            r_key_wr_err <= 1'b0;
        end else begin
            if (w_key_ok) r_keys[i_key_wr_addr] <= i_key_wr_data;
            r_key_wr_err <= i_key_wr_en && !w_key_ok;
        end
    end

    assign o_in_ready    = r_in_ready;
    assign o_out_valid   = w_out_valid;
    assign o_out_block   = {r_x, r_y};
    assign o_out_decrypt = r_dec;
    assign o_busy        = w_busy;
    assign o_key_wr_err  = r_key_wr_err;

endmodule

// File: tb/tb_simon_round_engine.sv
// Directed bench for simon_round_engine: three instances (16/32/1, 16/32/4, 16/1/1),
// expected results queued on accept and compared when the result handshake occurs.
module tb_simon_round_engine;

    typedef struct {
        logic [31:0] blk;
        logic        dec;
    } exp_t;

    localparam logic [31:0] PT = 32'h6565_6877;
    localparam logic [31:0] CT = 32'hc69b_e9bb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_en   [3];
    logic [4:0]  key_addr [3];
    logic        c_key_addr;
    logic [15:0] key_data [3];
    logic        key_err  [3];
    logic        in_valid [3];
    logic        in_ready [3];
    logic [31:0] in_block [3];
    logic        in_dec   [3];
    logic        out_valid[3];
    logic        out_ready[3];
    logic [31:0] out_block[3];
    logic        out_dec  [3];
    logic        busy     [3];

    logic [15:0] kexp [32];
    exp_t        sb [$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          acc_cyc = 0;

    always #5 clk = ~clk;

    simon_round_engine #(.WORD_W(16), .ROUNDS(32), .UNROLL(1)) u_a (
        .i_clk_simon(clk), .i_rst_simon(rst),
        .i_key_wr_en(key_en[0]), .i_key_wr_addr(key_addr[0]), .i_key_wr_data(key_data[0]),
        .o_key_wr_err(key_err[0]),
        .i_in_valid(in_valid[0]), .o_in_ready(in_ready[0]), .i_in_block(in_block[0]),
        .i_in_decrypt(in_dec[0]),
        .o_out_valid(out_valid[0]), .i_out_ready(out_ready[0]), .o_out_block(out_block[0]),
        .o_out_decrypt(out_dec[0]), .o_busy(busy[0])
    );

    simon_round_engine #(.WORD_W(16), .ROUNDS(32), .UNROLL(4)) u_b (
        .i_clk_simon(clk), .i_rst_simon(rst),
        .i_key_wr_en(key_en[1]), .i_key_wr_addr(key_addr[1]), .i_key_wr_data(key_data[1]),
        .o_key_wr_err(key_err[1]),
        .i_in_valid(in_valid[1]), .o_in_ready(in_ready[1]), .i_in_block(in_block[1]),
        .i_in_decrypt(in_dec[1]),
        .o_out_valid(out_valid[1]), .i_out_ready(out_ready[1]), .o_out_block(out_block[1]),
        .o_out_decrypt(out_dec[1]), .o_busy(busy[1])
    );

    simon_round_engine #(.WORD_W(16), .ROUNDS(1), .UNROLL(1)) u_c (
        .i_clk_simon(clk), .i_rst_simon(rst),
        .i_key_wr_en(key_en[2]), .i_key_wr_addr(c_key_addr), .i_key_wr_data(key_data[2]),
        .o_key_wr_err(key_err[2]),
        .i_in_valid(in_valid[2]), .o_in_ready(in_ready[2]), .i_in_block(in_block[2]),
        .i_in_decrypt(in_dec[2]),
        .o_out_valid(out_valid[2]), .i_out_ready(out_ready[2]), .o_out_block(out_block[2]),
        .o_out_decrypt(out_dec[2]), .o_busy(busy[2])
    );

    function automatic logic [15:0] rl(input logic [15:0] v, input int n);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = {r[14:0], r[15]};
        return r;
    endfunction

    function automatic logic [15:0] rr(input logic [15:0] v, input int n);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = {r[0], r[15:1]};
        return r;
    endfunction

    function automatic logic [15:0] fm(input logic [15:0] v);
        return (rl(v, 1) & rl(v, 8)) ^ rl(v, 2);
    endfunction

    // Reference cipher over the bench key table (or all-zero keys).
    function automatic logic [31:0] model(input logic [31:0] blk, input logic dec,
                                          input int rounds, input logic zero_keys);
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] t;
        logic [15:0] k;
        int          i;
        x = blk[31:16];
        y = blk[15:0];
        for (int r = 0; r < rounds; r++) begin
            i = dec ? rounds - 1 - r : r;
            k = zero_keys ? 16'h0 : kexp[i[4:0]];
            if (!dec) begin
                t = x; x = y ^ fm(x) ^ k; y = t;
            end else begin
                t = y; y = x ^ fm(y) ^ k; x = t;
            end
        end
        return {x, y};
    endfunction

    // Simon32/64 key schedule (m = 4, sequence z0).
    task automatic expand(input logic [63:0] key);
        logic [61:0] zc;
        logic [15:0] tmp;
        zc = 62'b01100111000011010100100010111110110011100001101010010001011111;
        for (int i = 0; i < 4; i++) kexp[i] = key[16*i +: 16];
        for (int i = 4; i < 32; i++) begin
            tmp     = rr(kexp[i-1], 3) ^ kexp[i-3];
            tmp     = tmp ^ rr(tmp, 1);
            kexp[i] = ~kexp[i-4] ^ tmp ^ {15'b0, zc[i-4]} ^ 16'h0003;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic write_key(input int d, input logic [4:0] addr, input logic [15:0] data,
                             input logic exp_err);
        key_en[d]   = 1'b1;
        key_addr[d] = addr;
        c_key_addr  = addr[0];
        key_data[d] = data;
        tick();
        key_en[d] = 1'b0;
        chk("key_wr_err", 32'(key_err[d]), 32'(exp_err));
    endtask

    task automatic send(input int d, input logic [31:0] blk, input logic dec,
                        input logic [31:0] exp_blk);
        int w;
        w = 0;
        while (!in_ready[d] && w < 200) begin
            tick();
            w++;
        end
        chk("in_ready_before_send", 32'(in_ready[d]), 32'd1);
        in_valid[d] = 1'b1;
        in_block[d] = blk;
        in_dec[d]   = dec;
        tick();
        in_valid[d] = 1'b0;
        acc_cyc     = cyc;
        sb.push_back('{exp_blk, dec});
        chk("busy_after_accept", 32'(busy[d]), 32'd1);
    endtask

    task automatic wait_out(input int d, input int lat);
        int w;
        w = 0;
        while (!out_valid[d] && w < 200) begin
            tick();
            w++;
        end
        chk("out_valid_seen", 32'(out_valid[d]), 32'd1);
        chk("latency", 32'(cyc - acc_cyc), 32'(lat));
    endtask

    task automatic pop_check(input int d);
        exp_t e;
        n_tests++;
        assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL sb_pop: observed output %h expected nothing queued", out_block[d]);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("out_block", out_block[d], e.blk);
            chk("out_decrypt", 32'(out_dec[d]), 32'(e.dec));
        end
    endtask

    task automatic handshake(input int d);
        out_ready[d] = 1'b1;
        tick();
        out_ready[d] = 1'b0;
        chk("in_ready_after_done", 32'(in_ready[d]), 32'd1);
        chk("out_valid_after_done", 32'(out_valid[d]), 32'd0);
    endtask

    task automatic run(input int d, input logic [31:0] blk, input logic dec,
                       input logic [31:0] exp_blk, input int lat);
        send(d, blk, dec, exp_blk);
        wait_out(d, lat);
        pop_check(d);
        handshake(d);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready[0]), 32'd1);
        chk({tag, "_out_valid"}, 32'(out_valid[0]), 32'd0);
        chk({tag, "_out_block"}, out_block[0], 32'd0);
        chk({tag, "_out_decrypt"}, 32'(out_dec[0]), 32'd0);
        chk({tag, "_key_wr_err"}, 32'(key_err[0]), 32'd0);
        chk({tag, "_busy"}, 32'(busy[0]), 32'd0);
    endtask

    initial begin
        logic [31:0] rnd;
        logic        seen;
        c_key_addr = 1'b0;
        for (int d = 0; d < 3; d++) begin
            key_en[d] = 1'b0; key_addr[d] = '0; key_data[d] = '0;
            in_valid[d] = 1'b0; in_block[d] = '0; in_dec[d] = 1'b0; out_ready[d] = 1'b0;
        end
        rst = 1'b1;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();
        expand(64'h1918_1110_0908_0100);

        // Single-round instance: basic round function and out-of-range key address.
        write_key(2, 5'd0, 16'h0000, 1'b0);
        run(2, 32'h0001_0000, 1'b0, 32'h0004_0001, 1);
        write_key(2, 5'd1, 16'hffff, 1'b1);
        tick();
        chk("key_wr_err_pulse", 32'(key_err[2]), 32'd0);
        run(2, 32'h0001_0000, 1'b0, 32'h0004_0001, 1);

        // Simon32/64 reference vector, one round per clock.
        for (int i = 0; i < 32; i++) write_key(0, 5'(i), kexp[i], 1'b0);
        run(0, PT, 1'b0, CT, 32);
        run(0, CT, 1'b1, PT, 32);
        rnd = $urandom;
        run(0, rnd, 1'b0, model(rnd, 1'b0, 32, 1'b0), 32);
        run(0, rnd, 1'b1, model(rnd, 1'b1, 32, 1'b0), 32);

        // Four rounds per clock.
        for (int i = 0; i < 32; i++) write_key(1, 5'(i), kexp[i], 1'b0);
        run(1, PT, 1'b0, CT, 8);
        run(1, CT, 1'b1, PT, 8);

        // Output stall with a second block waiting.
        send(0, PT, 1'b0, CT);
        wait_out(0, 32);
        in_valid[0] = 1'b1;
        in_block[0] = CT;
        in_dec[0]   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("stall_out_valid", 32'(out_valid[0]), 32'd1);
            chk("stall_out_block", out_block[0], CT);
            chk("stall_in_ready", 32'(in_ready[0]), 32'd0);
        end
        pop_check(0);
        handshake(0);
        sb.push_back('{PT, 1'b1});
        tick();
        in_valid[0] = 1'b0;
        acc_cyc     = cyc;
        chk("second_accept_busy", 32'(busy[0]), 32'd1);
        wait_out(0, 32);
        pop_check(0);
        handshake(0);

        // Key write while running is dropped and does not disturb the block.
        send(0, PT, 1'b0, CT);
        repeat (3) tick();
        write_key(0, 5'd5, 16'hdead, 1'b1);
        tick();
        chk("run_key_wr_err_pulse", 32'(key_err[0]), 32'd0);
        wait_out(0, 32);
        pop_check(0);
        handshake(0);

        // Reset at round 10 aborts the block and clears the key store.
        send(0, PT, 1'b0, CT);
        repeat (10) tick();
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrun_reset");
        sb.delete();
        tick();
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid[0]) seen = 1'b1;
        end
        chk("no_out_after_reset", 32'(seen), 32'd0);
        run(0, PT, 1'b0, model(PT, 1'b0, 32, 1'b1), 32);
        for (int i = 0; i < 32; i++) write_key(0, 5'(i), kexp[i], 1'b0);
        run(0, PT, 1'b0, CT, 32);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
